// File: rtl/johnson_seq_pkg.sv
// Shared FSM encoding for the Johnson step sequencer.
package johnson_seq_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/johnson_shift_bidir.sv
// Bidirectional N-bit Johnson counter; advances one state per enabled cycle.
module johnson_shift_bidir #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] q
);

  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  // Next phase: forward shifts right feeding ~lsb, reverse is its exact inverse.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (dir) begin
        q_d = {q_q[N-2:0], ~q_q[N-1]};
      end else begin
        q_d = {~q_q[0], q_q[N-1:1]};
      end
    end else begin
      q_d = q_q;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {N{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/johnson_step_sequencer.sv
// Command-driven stepper phase sequencer: runs a Johnson counter a given number of
// steps at a programmed rate, reporting completion or abort.
module johnson_step_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic [N-1:0]     phase,
  output logic             step_stb,
  output logic             busy,
  output logic [CNT_W-1:0] steps_left,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  seq_state_e       state_d, state_q;
  logic [DIV_W-1:0] presc_d, presc_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic             dir_d, dir_q;
  logic [CNT_W-1:0] steps_left_d, steps_left_q;
  logic             aborted_d, aborted_q;
  logic             done_d, done_q;
  logic             step_stb_d, step_stb_q;
  logic             busy_d, busy_q;
  logic             cmd_ready_d, cmd_ready_q;
  logic             step_fire;

  // FSM next state, prescaler, step counter and flags.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    div_d        = div_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;
    step_fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d        = cmd_dir;
          div_d        = cmd_div;
          presc_d      = DIV_ZERO;
          steps_left_d = cmd_steps;
          aborted_d    = 1'b0;
          state_d      = (cmd_steps == CNT_ZERO) ? ST_FIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort beats a coinciding step, so the unexecuted count stays >= 1.
        if (abort) begin
          state_d = ST_FIN;
        end else if (presc_q == div_q) begin
          presc_d      = DIV_ZERO;
          step_fire    = 1'b1;
          steps_left_d = steps_left_q - CNT_ONE;
          state_d      = (steps_left_q == CNT_ONE) ? ST_FIN : ST_RUN;
        end else begin
          presc_d = presc_q + DIV_ONE;
        end
      end
      ST_FIN: begin
        done_d    = 1'b1;
        aborted_d = (steps_left_q != CNT_ZERO);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    step_stb_d  = step_fire;
    busy_d      = (state_d == ST_RUN);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= DIV_ZERO;
      div_q        <= DIV_ZERO;
      dir_q        <= 1'b0;
      steps_left_q <= CNT_ZERO;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
      step_stb_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      div_q        <= div_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      aborted_q    <= aborted_d;
      done_q       <= done_d;
      step_stb_q   <= step_stb_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  johnson_shift_bidir #(.N(N)) u_phase (
    .clk (clk),
    .rst (rst),
    .en  (step_fire),
    .dir (dir_q),
    .q   (phase)
  );

  assign cmd_ready  = cmd_ready_q;
  assign step_stb   = step_stb_q;
  assign busy       = busy_q;
  assign steps_left = steps_left_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule
